crossbar_switch_rr: RTL and testbench
=====================================

# crossbar_switch_rr

Registered N×N crossbar switch with per-port valid/ready handshakes, the successor to the combinational barrel-shifter crossbar. Two routing modes: rotate, which keeps barrel-shifter semantics, and destination-routed, where each input names its output. Contention on an output is resolved by a per-output round-robin arbiter, and each output has a one-entry register. It sits between the input port buffers and the output port logic of the switch fabric.

## Interface
- N, 8, number of input and output ports (≥2; need not be a power of two).
- W, 8, data width per port.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = rotate mode, 1 = destination mode; sampled every cycle.
- shift  in  $clog2(N)  rotate amount; used only in rotate mode.
- in_valid  in  [N-1:0]  input i offers a word.
- in_data  in  [N-1:0][W-1:0]  input words.
- in_dest  in  [N-1:0][$clog2(N)-1:0]  destination output per input; used only in destination mode.
- in_ready  out  [N-1:0]  input i's word is accepted this cycle.
- out_valid  out  [N-1:0]  output register j holds a word.
- out_data  out  [N-1:0][W-1:0]  output register contents.
- out_ready  in  [N-1:0]  downstream consumes output j.

## Operation
- Request target for input i:
  - Rotate mode: (i − shift) mod N. Equivalently, out[k] receives in[(k+shift) mod N].
  - Destination mode: in_dest[i].
- Requests with target ≥ N are never granted, and in_ready[i] stays 0.
- Output j can load when `!out_valid[j] || out_ready[j]`.
- Arbiter j sees the requests from inputs with in_valid=1 and target=j.
- Arbiter j grants only when output j can load. It picks the first requester at or after ptr[j], wrapping modulo N.
- Grant behaviour:
  - in_ready[i] = 1 exactly when input i holds a grant; at most one grant per input and one per output.
  - in_ready may depend combinationally on in_valid, in_dest, mode, shift and out_ready.
- On a grant to input g for output j:
  - out_data[j] ← in_data[g] and out_valid[j] ← 1.
  - ptr[j] ← (g+1) mod N, with explicit wrap for N not a power of two.
- Pop without load: out_valid[j] ← 0 and out_data[j] holds its value.
- Pop and load in the same cycle: the register is replaced, giving full throughput of one word per output per cycle.
- Changing mode or shift affects only new grants. Words already in output registers are unaffected.
- In rotate mode the mapping is a permutation, so every valid input whose output can load is granted.

## Timing
- Latency: a word accepted at edge t appears on out_data/out_valid after edge t (one cycle).
- Reset, asynchronous on assertion: out_valid=0, out_data=0, all ptr=0, in_ready=0 while rst_n=0.
- Release is synchronised to clk by the surrounding design.
- Reset mid-operation discards all held words. No output is presented until new inputs are accepted.
- Output-side rules:
  - out_valid never drops without out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
- Input side: a held-off input may change or withdraw its word. The block imposes no input stability rule.

## Structure
- Package crossbar_pkg holds:
  - mode typedef (MODE_ROTATE=1'b0, MODE_DEST=1'b1);
  - a helper for the index width ($clog2(N), minimum 1);
  - a wrap-increment function for the pointers.
- Sub-module rr_arbiter #(N):
  - inputs: req[N-1:0], en, and a pointer register that advances on grant;
  - outputs: one-hot gnt[N-1:0] and an encoded grant index.
- Instantiate one rr_arbiter per output in a generate loop. in_ready is the OR of the gnt bits across outputs.

## Test plan
All scenarios use N=4, W=8.
1. **Rotate mode:** mode=0, shift=1, all in_valid=1, in_data={0x13,0x12,0x11,0x10}, all out_ready=1 → next cycle out_data[0..3]=0x11,0x12,0x13,0x10, all out_valid=1, all in_ready were 1.
2. **Contention:** mode=1, inputs 0, 2 and 3 valid with dest=1 (data 0xA0, 0xA2, 0xA3), ptr reset → out_data[1] is 0xA0, 0xA2, 0xA3 on three consecutive cycles, out_valid[1] continuously 1, ptr[1] ends at 0.
3. **Backpressure:** output 2 full with 0x55, out_ready[2]=0, input 1 valid dest=2 → in_ready[1]=0, out_data[2] holds 0x55. Raising out_ready[2] → 0x55 is popped and input 1's word is loaded in the same cycle.
4. **Pointer wrap:** ptr[0]=3, inputs 0 and 3 request output 0 → input 3 is granted, ptr[0] becomes 0, input 0 is granted on the next cycle.
5. **Reset mid-stream:** rst_n dropped asynchronously while out_valid=4'b1111 → out_valid=0 and out_data=0 immediately, without waiting for a clock edge. After release, no output appears until inputs are offered.
6. **Mode switch:** words loaded in rotate mode with shift=3, then mode=1 on the next cycle → held words drain unchanged and new words follow in_dest.

Source files
------------

// File: rtl/crossbar_switch_rr_pkg.sv
// Shared types and helpers for the registered round-robin crossbar.
// Helpers are constant functions so they can size ports and parameters.
package crossbar_pkg;

  typedef enum logic {
    MODE_ROTATE = 1'b0,
    MODE_DEST   = 1'b1
  } mode_e;

  // Port-index width: $clog2(n), but never below one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Modulo-n increment. The wrap is explicit so that n need not be a power of two.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/crossbar_switch_rr_if.sv
// Port bundle of the crossbar: routing controls, N input channels, N output channels.
// Valid/ready: a word moves on a rising edge where valid && ready are both 1. On the input
// side, ready may depend combinationally on valid. On the output side, valid stays up and
// data stays stable until ready is seen.
interface crossbar_switch_rr_if #(
    parameter int N = 8,
    parameter int W = 8
);
    import crossbar_pkg::*;
    localparam int IW = crossbar_pkg::idx_w(N);

    mode_e                  mode;
    logic [IW-1:0]          shift;
    logic [N-1:0]           in_valid;
    logic [N-1:0][W-1:0]    in_data;
    logic [N-1:0][IW-1:0]   in_dest;
    logic [N-1:0]           in_ready;
    logic [N-1:0]           out_valid;
    logic [N-1:0][W-1:0]    out_data;
    logic [N-1:0]           out_ready;

    modport master (
        output mode, shift, in_valid, in_data, in_dest, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  mode, shift, in_valid, in_data, in_dest, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/crossbar_switch_rr_arbiter.sv
// Round-robin arbiter for one crossbar output. It grants the first requester at or after
// the pointer, and the pointer moves just past the winner.
module rr_arbiter
    import crossbar_pkg::*;
#(
    parameter int N = 8,
    localparam int IW = crossbar_pkg::idx_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  i_req,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic [IW-1:0] o_ptr
);
    logic [IW-1:0] r_ptr;

    always_comb begin
        logic [IW-1:0] cand;
        logic          found;
        cand      = r_ptr;
        found     = 1'b0;
        o_gnt     = '0;
        o_gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && i_en && i_req[cand]) begin
                found       = 1'b1;
                o_gnt[cand] = 1'b1;
                o_gnt_idx   = cand;
            end
            cand = IW'(wrap_inc(int'(cand), N));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (|o_gnt) begin
            r_ptr <= IW'(wrap_inc(int'(o_gnt_idx), N));
        end
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/crossbar_switch_rr.sv
// Registered NxN crossbar with rotate and destination routing. Each output has one
// round-robin arbiter and a one-word output register.
module crossbar_switch_rr
    import crossbar_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 8,
    localparam int IW = crossbar_pkg::idx_w(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    crossbar_switch_rr_if.slave  bus,
    output logic [N-1:0][IW-1:0] o_dbg_ptr
);
    logic [IW-1:0]       w_tgt [N];
    logic [N-1:0]        w_tgt_ok;
    logic [N-1:0]        w_req [N];
    logic [N-1:0]        w_gnt [N];
    logic [IW-1:0]       w_gnt_idx [N];
    logic [N-1:0]        w_can_load;
    logic [N-1:0]        w_in_ready;
    logic [N-1:0]        r_out_valid;
    logic [N-1:0][W-1:0] r_out_data;

    // In rotate mode, input i targets output (i - shift) mod N. Here shift may exceed N-1.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (bus.mode == MODE_ROTATE) begin
                w_tgt[i]    = IW'((i + N - (int'(bus.shift) % N)) % N);
                w_tgt_ok[i] = 1'b1;
            end else begin
                w_tgt[i]    = bus.in_dest[i];
                w_tgt_ok[i] = int'(bus.in_dest[i]) < N;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_req[j] = '0;
            for (int i = 0; i < N; i++) begin
                w_req[j][i] = bus.in_valid[i] && w_tgt_ok[i] && (w_tgt[i] == IW'(j));
            end
        end
    end

    // Gating with rst_n keeps in_ready low for the whole time reset is held.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_can_load[j] = rst_n && (!r_out_valid[j] || bus.out_ready[j]);
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_arb
        rr_arbiter #(.N(N)) u_arb (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_req     (w_req[j]),
            .i_en      (w_can_load[j]),
            .o_gnt     (w_gnt[j]),
            .o_gnt_idx (w_gnt_idx[j]),
            .o_ptr     (o_dbg_ptr[j])
        );
    end

    always_comb begin
        w_in_ready = '0;
        for (int j = 0; j < N; j++) begin
            w_in_ready |= w_gnt[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= '0;
            r_out_data  <= '0;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (|w_gnt[j]) begin
                    r_out_valid[j] <= 1'b1;
                    r_out_data[j]  <= bus.in_data[w_gnt_idx[j]];
                end else if (bus.out_ready[j]) begin
                    r_out_valid[j] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_crossbar_switch_rr.sv
// Bench for crossbar_switch_rr. It runs directed scenarios and a randomized phase, and checks
// every cycle against an abstract output-register/pointer model and per-output word queues.
module tb_crossbar_switch_rr;
  import crossbar_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  crossbar_switch_rr_if #(.N(N), .W(W)) bus ();
  logic [N-1:0][IW-1:0] dbg_ptr;

  crossbar_switch_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .o_dbg_ptr (dbg_ptr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_ptr   [N] = '{default: 0};
  bit           m_valid [N] = '{default: 1'b0};
  logic [W-1:0] m_data  [N] = '{default: '0};
  int           m_g     [N];
  logic [N-1:0] m_rdy;
  logic [W-1:0] exp_q   [N][$];

  function automatic int target(input int i);
    if (bus.mode == MODE_ROTATE) return ((i - int'(bus.shift)) % N + N) % N;
    return int'(bus.in_dest[i]);
  endfunction

  // Grant to output j: the first valid input that targets j, searched from ptr[j] with wrap.
  task automatic predict();
    int s;
    m_rdy = '0;
    for (int j = 0; j < N; j++) begin
      m_g[j] = -1;
      if (rst_n && (!m_valid[j] || bus.out_ready[j])) begin
        for (int k = 0; k < N; k++) begin
          s = (m_ptr[j] + k) % N;
          if (m_g[j] < 0 && bus.in_valid[s] && target(s) == j) begin
            m_g[j] = s;
            m_rdy[s] = 1'b1;
          end
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) begin
        m_ptr[j] = 0; m_valid[j] = 1'b0; m_data[j] = '0;
        exp_q[j].delete();
      end
    end else begin
      predict();
      for (int j = 0; j < N; j++) begin
        if (m_g[j] >= 0) begin
          m_data[j]  = bus.in_data[m_g[j]];
          m_valid[j] = 1'b1;
          m_ptr[j]   = (m_g[j] + 1) % N;
          exp_q[j].push_back(bus.in_data[m_g[j]]);
        end else if (bus.out_ready[j]) begin
          m_valid[j] = 1'b0;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [W-1:0] w;
    predict();
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    for (int j = 0; j < N; j++) begin
      chk($sformatf("out_valid[%0d]", j), 32'(bus.out_valid[j]), 32'(m_valid[j]));
      chk($sformatf("out_data[%0d]", j), 32'(bus.out_data[j]), 32'(m_data[j]));
      chk($sformatf("ptr[%0d]", j), 32'(dbg_ptr[j]), 32'(m_ptr[j]));
      if (bus.out_valid[j] && bus.out_ready[j]) begin
        w = (exp_q[j].size() > 0) ? exp_q[j].pop_front() : 'x;
        chk($sformatf("popped_word[%0d]", j), 32'(bus.out_data[j]), 32'(w));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.mode      = MODE_ROTATE;
    bus.shift     = '0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.in_dest   = '0;
    bus.out_ready = '1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock. Inputs accepted on this edge then withdraw their word, as a source buffer would.
  task automatic step();
    logic [N-1:0] acc;
    #1;
    acc = bus.in_ready;
    @(posedge clk);
    #1;
    bus.in_valid = bus.in_valid & ~acc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_out_data", 32'(bus.out_data), 32'h0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'h0);
    do_reset();

    // Rotate, shift=1
    bus.mode = MODE_ROTATE; bus.shift = 2'd1;
    bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.in_valid = 4'hf;
    settle();
    chk("s1_in_ready", 32'(bus.in_ready), 32'hf);
    step();
    chk("s1_out_valid", 32'(bus.out_valid), 32'hf);
    chk("s1_out_data", 32'(bus.out_data), 32'h10131211);

    // Contention on output 1
    do_reset();
    bus.mode = MODE_DEST;
    bus.in_dest = {2'd1, 2'd1, 2'd1, 2'd1};
    bus.in_data = {8'hA3, 8'hA2, 8'h00, 8'hA0};
    bus.in_valid = 4'b1101;
    step();
    chk("s2_word0", 32'(bus.out_data[1]), 32'hA0);
    chk("s2_valid0", 32'(bus.out_valid[1]), 32'h1);
    step();
    chk("s2_word1", 32'(bus.out_data[1]), 32'hA2);
    chk("s2_valid1", 32'(bus.out_valid[1]), 32'h1);
    step();
    chk("s2_word2", 32'(bus.out_data[1]), 32'hA3);
    chk("s2_valid2", 32'(bus.out_valid[1]), 32'h1);
    chk("s2_ptr1", 32'(dbg_ptr[1]), 32'h0);

    // Backpressure on output 2
    bus.out_ready = 4'b1011;
    bus.in_dest[0] = 2'd2; bus.in_data[0] = 8'h55; bus.in_valid = 4'b0001;
    step();
    chk("s3_full", 32'(bus.out_data[2]), 32'h55);
    bus.in_dest[1] = 2'd2; bus.in_data[1] = 8'h66; bus.in_valid = 4'b0010;
    settle();
    chk("s3_held_off", 32'(bus.in_ready[1]), 32'h0);
    step();
    chk("s3_hold_data", 32'(bus.out_data[2]), 32'h55);
    chk("s3_hold_valid", 32'(bus.out_valid[2]), 32'h1);
    bus.out_ready[2] = 1'b1;
    settle();
    chk("s3_released", 32'(bus.in_ready[1]), 32'h1);
    step();
    chk("s3_replaced", 32'(bus.out_data[2]), 32'h66);
    chk("s3_repl_valid", 32'(bus.out_valid[2]), 32'h1);

    // Pointer wrap on output 0
    do_reset();
    bus.mode = MODE_DEST;
    bus.in_dest[2] = 2'd0; bus.in_data[2] = 8'h22; bus.in_valid = 4'b0100;
    step();
    chk("s4_ptr_at3", 32'(dbg_ptr[0]), 32'h3);
    bus.in_dest[0] = 2'd0; bus.in_dest[3] = 2'd0;
    bus.in_data[0] = 8'h30; bus.in_data[3] = 8'h33;
    bus.in_valid = 4'b1001;
    settle();
    chk("s4_grant3", 32'(bus.in_ready), 32'h8);
    step();
    chk("s4_word3", 32'(bus.out_data[0]), 32'h33);
    chk("s4_ptr_wrap", 32'(dbg_ptr[0]), 32'h0);
    settle();
    chk("s4_grant0", 32'(bus.in_ready), 32'h1);
    step();
    chk("s4_word0", 32'(bus.out_data[0]), 32'h30);

    // Asynchronous reset while all outputs are full
    bus.mode = MODE_ROTATE; bus.shift = 2'd0;
    bus.in_data = {8'h53, 8'h52, 8'h51, 8'h50};
    bus.in_valid = 4'hf; bus.out_ready = 4'h0;
    step();
    chk("s5_full", 32'(bus.out_valid), 32'hf);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_valid", 32'(bus.out_valid), 32'h0);
    chk("s5_async_data", 32'(bus.out_data), 32'h0);
    chk("s5_async_ready", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.in_valid = '0; bus.out_ready = 4'hf;
    repeat (3) begin
      step();
      chk("s5_quiet", 32'(bus.out_valid), 32'h0);
    end

    // Mode switch with words held
    bus.mode = MODE_ROTATE; bus.shift = 2'd3;
    bus.in_data = {8'h63, 8'h62, 8'h61, 8'h60};
    bus.in_valid = 4'hf; bus.out_ready = 4'h0;
    step();
    chk("s6_rotated", 32'(bus.out_data), 32'h62616063);
    bus.mode = MODE_DEST;
    bus.in_dest = {2'd0, 2'd1, 2'd2, 2'd3};
    bus.in_data = {8'h73, 8'h72, 8'h71, 8'h70};
    bus.in_valid = 4'hf;
    settle();
    chk("s6_blocked", 32'(bus.in_ready), 32'h0);
    step();
    chk("s6_held", 32'(bus.out_data), 32'h62616063);
    chk("s6_held_valid", 32'(bus.out_valid), 32'hf);
    bus.out_ready = 4'hf;
    settle();
    chk("s6_accept", 32'(bus.in_ready), 32'hf);
    step();
    chk("s6_dest_words", 32'(bus.out_data), 32'h70717273);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) bus.mode = mode_e'($urandom_range(0, 1));
      bus.shift = IW'($urandom_range(0, N - 1));
      for (int i = 0; i < N; i++) begin
        if (!bus.in_valid[i] || $urandom_range(0, 3) == 0) begin
          bus.in_valid[i] = ($urandom_range(0, 2) != 0);
          bus.in_data[i]  = W'($urandom_range(0, 255));
          bus.in_dest[i]  = IW'($urandom_range(0, N - 1));
        end
        bus.out_ready[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
